// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Constants and types shared by the fetch stage and the decoder:
//   datapath width, the canonical NOP encoding, major opcodes and the fetch FSM
//   state enum.
package riscv_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h00000013;   // addi x0, x0, 0

    // Major opcodes (InstrD[6:0]), shared with main_decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   DEPTH-entry FIFO holding {pc, instruction} pairs between instruction memory
//   and decode. Synchronous active-low reset; flush empties it in one cycle.
//   No bypass: a pushed entry becomes visible at the head the cycle after.
// Ports
//   clk, rst        clock, synchronous active-low reset
//   flush           drop all entries (wins over push/pop)
//   push, wdata     write an entry at the tail
//   pop             retire the head entry
//   rdata           head entry (undefined while empty)
//   count           number of valid entries, 0..DEPTH
//   empty           count == 0
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap for free
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch stage feeding decode. Owns the PC, issues one word read at a time to
//   instruction memory, buffers returned words in fetch_fifo and presents the
//   head with pre-sliced opcode fields. A redirect (PCSrc) reloads the PC,
//   flushes the FIFO and discards the response of any in-flight request.
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   imem_req/addr/gnt         request handshake, word address = PC
//   imem_rvalid/rdata         in-order response, one per granted request
//   PCSrc, PCTarget           redirect pulse and target
//   dec_ready                 decode consumes the head this cycle
//   instr_valid, InstrD, PCD  head entry (InstrD = NOP when empty)
//   Op, funct3, funct7        InstrD[6:0], InstrD[14:12], InstrD[30]
//   fetch_cnt, flush_cnt      pop / redirect counters, only when
//                             FETCH_PERF_CNT_EN is defined
//
// state   | meaning
// IDLE    | one cycle after reset, no requests
// FETCH   | issue requests while FIFO + in-flight has room
// DISCARD | wrong-path request in flight; drop its response
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int               XLEN     = riscv_pkg::XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    input  logic             PCSrc,
    input  logic [XLEN-1:0]  PCTarget,
    input  logic             dec_ready,
    output logic             instr_valid,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [6:0]       Op,
    output logic [2:0]       funct3,
    output logic             funct7
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic                  outst_q, outst_d;
    logic [XLEN-1:0]       req_pc_q;

    logic                  push, pop, flush, grant;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [XLEN+31:0]      head;
    logic [CW:0]           occ;
    logic                  unused_target_lsbs;

    assign unused_target_lsbs = ^PCTarget[1:0];

    assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, outst_q};
    assign imem_addr = pc_q;
    assign pop       = instr_valid && dec_ready && !PCSrc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        outst_d  = outst_q;
        imem_req = 1'b0;
        grant    = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // A response arriving this cycle frees the single request slot
                imem_req = (!outst_q || imem_rvalid) && (occ < (CW+1)'(DEPTH));
                grant    = imem_req && imem_gnt;
                push     = imem_rvalid && outst_q && !PCSrc;
                if (grant) begin
                    outst_d = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                end else if (imem_rvalid) begin
                    outst_d = 1'b0;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    outst_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides the PC; a same-cycle grant still leaves a
        // (wrong-path) request in flight, so its response must be discarded.
        if (PCSrc) begin
            pc_d    = {PCTarget[XLEN-1:2], 2'b00};
            flush   = 1'b1;
            state_d = outst_d ? DISCARD : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            outst_q  <= 1'b0;
            req_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            if (grant) req_pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign InstrD      = instr_valid ? head[31:0] : NOP;
    assign PCD         = instr_valid ? head[XLEN+31:32] : RESET_PC;
    assign Op          = InstrD[6:0];
    assign funct3      = InstrD[14:12];
    assign funct7      = InstrD[30];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pop)   fetch_cnt <= fetch_cnt + 32'd1;
            if (PCSrc) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue with a transaction-level model
//   (queue of expected {pc, instr} entries) checked every cycle, plus literal
//   expectations for the key scenarios. Honours FETCH_PERF_CNT_EN.
module tb_instr_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] NOPV   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'hDEADBEEF;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic        dec_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [6:0]  Op;
    logic [2:0]  funct3;
    logic        funct7;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    instr_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .dec_ready(dec_ready),
        .instr_valid(instr_valid), .InstrD(InstrD), .PCD(PCD),
        .Op(Op), .funct3(funct3), .funct7(funct7)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    // ---------------- memory responder: fixed latency, one in flight -------
    int          lat = 1;
    bit          p_valid = 1'b0;
    logic [31:0] p_addr = '0;
    int          p_left = 0;

    always @(posedge clk) begin
        logic        g;
        logic [31:0] ga;
        g  = (imem_req === 1'b1) && imem_gnt;
        ga = imem_addr;
        if (imem_rvalid) p_valid = 1'b0;
        else if (p_valid) p_left--;
        if (g) begin
            p_valid = 1'b1;
            p_addr  = ga;
            p_left  = lat;
        end
        #2;
        imem_rvalid = p_valid && (p_left == 1);
        imem_rdata  = imem_rvalid ? instr_of(p_addr) : 32'hDEADBEEF;
    end

    // ---------------- behavioural model ------------------------------------
    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        m_q[$];
    bit          m_run = 1'b0;
    bit          m_out = 1'b0;      // a request is in flight
    bit          m_wrong = 1'b0;    // ... and it is wrong-path
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_out_pc = '0;
    int          m_pops = 0;
    int          m_flushes = 0;

    function automatic bit exp_req();
        return m_run && !m_wrong && (!m_out || imem_rvalid) &&
               (m_q.size() + int'(m_out) < DEPTH);
    endfunction

    always @(posedge clk) begin
        bit rq, g, resp, pp;
        if (!rst) begin
            m_run = 0; m_out = 0; m_wrong = 0; m_q.delete();
            m_pc = RST_PC; m_pops = 0; m_flushes = 0;
        end else if (!m_run) begin
            m_run = 1;
        end else begin
            rq   = exp_req();
            g    = rq && imem_gnt;
            resp = imem_rvalid && m_out;
            pp   = (m_q.size() != 0) && dec_ready && !PCSrc;
            if (pp) m_pops++;
            if (PCSrc) begin
                m_flushes++;
                m_q.delete();
                m_pc = {PCTarget[31:2], 2'b00};
                if (g) begin m_out = 1; m_wrong = 1; end
                else if (resp) begin m_out = 0; m_wrong = 0; end
                else if (m_out) m_wrong = 1;
            end else begin
                if (pp) void'(m_q.pop_front());
                if (resp && !m_wrong) m_q.push_back('{pc: m_out_pc, ins: instr_of(m_out_pc)});
                if (resp) begin m_out = 0; m_wrong = 0; end
                if (g) begin m_out = 1; m_wrong = 0; m_out_pc = m_pc; m_pc = m_pc + 32'd4; end
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        bit   v, rq;
        ent_t h;
        if (chk_en) begin
            v  = (m_q.size() != 0);
            h  = v ? m_q[0] : '{pc: RST_PC, ins: NOPV};
            rq = exp_req();
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, v});
            chk("InstrD", InstrD, h.ins);
            chk("Op", {25'b0, Op}, {25'b0, h.ins[6:0]});
            chk("funct3", {29'b0, funct3}, {29'b0, h.ins[14:12]});
            chk("funct7", {31'b0, funct7}, {31'b0, h.ins[30]});
            if (v) chk("PCD", PCD, h.pc);
            chk("imem_req", {31'b0, imem_req}, {31'b0, rq});
            if (rq) chk("imem_addr", imem_addr, m_pc);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // wait (bounded) for a negedge where instr_valid is high
    task automatic wait_valid(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin ok = 1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req) begin ok = 1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- directed scenarios -----------------------------------
    initial begin
        bit          ok;
        int          n;
        logic [31:0] held_pc;
        logic [31:0] pcs [3];

        // reset
        rst = 0;
        step();
        chk_en = 1;
        step(); step();
        @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_InstrD", InstrD, NOPV);
        chk("rst_PCD", PCD, RST_PC);
        chk("rst_req", {31'b0, imem_req}, 32'd0);

        // 1: streaming, first valid 3 edges after last reset edge
        @(posedge clk); #2;
        rst = 1; imem_gnt = 1; dec_ready = 1; lat = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (instr_valid) break;
        end
        chk("t1_latency", n, 32'd3);
        pcs[0] = PCD;
        @(negedge clk); pcs[1] = instr_valid ? PCD : 32'hFFFFFFFF;
        @(negedge clk); pcs[2] = instr_valid ? PCD : 32'hFFFFFFFF;
        chk("t1_pcd0", pcs[0], 32'h0);
        chk("t1_pcd1", pcs[1], 32'h4);
        chk("t1_pcd2", pcs[2], 32'h8);

        // 2: decode stalls 10 cycles
        #1 dec_ready = 0;
        @(negedge clk);
        held_pc = PCD;
        repeat (9) @(negedge clk);
        chk("t2_valid", {31'b0, instr_valid}, 32'd1);
        chk("t2_req_off", {31'b0, imem_req}, 32'd0);
        chk("t2_head_held", PCD, held_pc);
        chk("t2_model_fill", m_q.size(), 32'd4);
        #1 dec_ready = 1; imem_gnt = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (instr_valid) n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("t2_pops", n, 32'd4);

        // 3: redirect while a request is outstanding
        #1 imem_gnt = 1; lat = 3;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin ok = 1; break; end
        end
        if (!ok) chk("t3_grant_timeout", 32'd0, 32'd1);
        step();
        PCSrc = 1; PCTarget = 32'h103;
        step();
        PCSrc = 0;
        wait_req("t3_req", ok);
        if (ok) chk("t3_addr", imem_addr, 32'h100);
        wait_valid("t3_valid", ok);
        if (ok) begin
            chk("t3_pcd", PCD, 32'h100);
            chk("t3_instr", InstrD, instr_of(32'h100));
        end

        // 4: redirect coinciding with rvalid, grant and dec_ready
        #1 lat = 1;
        repeat (8) step();
        PCSrc = 1; PCTarget = 32'h200;
        @(negedge clk);
        chk("t4_setup", {28'b0, imem_rvalid, imem_req, instr_valid, imem_gnt}, 32'hF);
        step();
        PCSrc = 0;
        @(negedge clk);
        chk("t4_flushed", {31'b0, instr_valid}, 32'd0);
        wait_valid("t4_valid", ok);
        if (ok) chk("t4_pcd", PCD, 32'h200);

        // 5: reset mid-stream with 3 entries queued
        #1 dec_ready = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_q.size() == 3) begin ok = 1; break; end
        end
        if (!ok) chk("t5_fill_timeout", 32'd0, 32'd1);
        #1 rst = 0;
        @(negedge clk);
        chk("t5_valid", {31'b0, instr_valid}, 32'd0);
        chk("t5_InstrD", InstrD, NOPV);
        chk("t5_req", {31'b0, imem_req}, 32'd0);
        step();
        rst = 1;
        wait_req("t5_req", ok);
        if (ok) chk("t5_addr", imem_addr, RST_PC);
        wait_valid("t5_valid", ok);
        if (ok) chk("t5_pcd", PCD, RST_PC);

        // 6: 20 pops and 3 redirects from a fresh reset
        #1 rst = 0;
        step();
        rst = 1;
        for (int i = 0; i < 200; i++) begin
            dec_ready = (m_pops < 20) && (i % 3 != 1);
            PCSrc     = (i == 5) || (i == 15) || (i == 25);
            PCTarget  = 32'h400 + 32'(i) * 32'd16;
            imem_gnt  = (i % 7 != 3);
            lat       = (i < 12) ? 1 : 2;
            step();
            if (m_pops >= 20 && i >= 30) break;
        end
        dec_ready = 0; PCSrc = 0;
        @(negedge clk);
        chk("t6_model_pops", m_pops, 32'd20);
        chk("t6_model_flushes", m_flushes, 32'd3);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_fetch_cnt", fetch_cnt, 32'd20);
        chk("t6_flush_cnt", flush_cnt, 32'd3);
`endif
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
